// File: rtl/atmega_pll_pkg.sv
// Shared definitions for the ATmega PLL configuration sequencer:
// FSM state encoding plus PLLCSR bit positions and PLLFRQ field masks.
package atmega_pll_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_REQ_W,
        ST_WR_FRQ,
        ST_WR_CSR,
        ST_GAP,
        ST_REQ_R,
        ST_RD_CSR,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam int PLLCSR_PLOCK  = 0;
    localparam int PLLCSR_PLLE   = 1;
    localparam int PLLCSR_PINDIV = 4;

    localparam logic [7:0] PLLFRQ_PDIV_MASK   = 8'h0F;
    localparam logic [7:0] PLLFRQ_PLLTM_MASK  = 8'h30;
    localparam logic [7:0] PLLFRQ_PLLUSB_MASK = 8'h40;

endpackage

// File: rtl/atmega_pll_cfg_seq.sv
// Bus initiator that writes PLLFRQ and PLLCSR, then polls PLLCSR.PLOCK
// through a req/gnt arbiter until lock or timeout.
module atmega_pll_cfg_seq
    import atmega_pll_pkg::*;
#(
    parameter int                           BUS_ADDR_DATA_LEN = 16,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] PLLCSR_ADDR       = 'h49,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] PLLFRQ_ADDR       = 'h52,
    parameter int                           LOCK_TIMEOUT      = 1024,
    parameter int                           POLL_GAP          = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic [7:0]                   cfg_pllfrq,
    input  logic [7:0]                   cfg_pllcsr,
    output logic                         bus_req,
    input  logic                         bus_gnt,
    output logic [BUS_ADDR_DATA_LEN-1:0] addr_dat,
    output logic                         wr_dat,
    output logic                         rd_dat,
    output logic [7:0]                   bus_dat_out,
    input  logic [7:0]                   bus_dat_in,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [7:0]                   last_pllcsr
);

    localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int GAP_W = $clog2(POLL_GAP + 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(LOCK_TIMEOUT);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

    state_e                         state_q, state_d;
    logic [7:0]                     frq_q, frq_d;
    logic [7:0]                     csr_q, csr_d;
    logic [TMO_W-1:0]               tmo_q, tmo_d;
    logic [GAP_W-1:0]               gap_q, gap_d;
    logic                           error_q, error_d;
    logic [7:0]                     last_q, last_d;
    logic                           req_q, req_d;
    logic                           wr_q, wr_d;
    logic                           rd_q, rd_d;
    logic [BUS_ADDR_DATA_LEN-1:0]   addr_q, addr_d;
    logic [7:0]                     dat_q, dat_d;

    always_comb begin
        state_d = state_q;
        frq_d   = frq_q;
        csr_d   = csr_q;
        tmo_d   = tmo_q;
        gap_d   = gap_q;
        error_d = error_q;
        last_d  = last_q;

        // Arbiter wait time in REQ_R counts against the lock budget too.
        if ((state_q == ST_GAP || state_q == ST_REQ_R || state_q == ST_RD_CSR) &&
            (tmo_q < TMO_MAX)) begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    frq_d   = cfg_pllfrq;
                    csr_d   = cfg_pllcsr;
                    error_d = 1'b0;
                    tmo_d   = '0;
                    state_d = ST_REQ_W;
                end
            end
            ST_REQ_W: begin
                if (bus_gnt) state_d = ST_WR_FRQ;
            end
            ST_WR_FRQ: state_d = ST_WR_CSR;
            ST_WR_CSR: begin
                gap_d   = '0;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) state_d = ST_REQ_R;
                else                   gap_d   = gap_q + GAP_W'(1);
            end
            ST_REQ_R: begin
                if (bus_gnt) state_d = ST_RD_CSR;
            end
            ST_RD_CSR: begin
                last_d = bus_dat_in;
                if (bus_dat_in[PLLCSR_PLOCK]) begin
                    state_d = ST_DONE;
                end else if (tmo_q >= TMO_MAX) begin
                    state_d = ST_ERR;
                end else begin
                    gap_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (abort && state_q != ST_IDLE) state_d = ST_IDLE;
        if (state_d == ST_ERR) error_d = 1'b1;
    end

    // Bus-side registers follow the upcoming state so they line up with it.
    always_comb begin
        req_d  = (state_d == ST_REQ_W) || (state_d == ST_WR_FRQ) || (state_d == ST_WR_CSR) ||
                 (state_d == ST_REQ_R) || (state_d == ST_RD_CSR);
        wr_d   = (state_d == ST_WR_FRQ) || (state_d == ST_WR_CSR);
        rd_d   = (state_d == ST_RD_CSR);
        addr_d = '0;
        dat_d  = '0;
        if (state_d == ST_WR_FRQ) begin
            addr_d = PLLFRQ_ADDR;
            dat_d  = frq_q;
        end else if (state_d == ST_WR_CSR) begin
            addr_d = PLLCSR_ADDR;
            dat_d  = csr_q;
        end else if (state_d == ST_RD_CSR) begin
            addr_d = PLLCSR_ADDR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            frq_q   <= '0;
            csr_q   <= '0;
            tmo_q   <= '0;
            gap_q   <= '0;
            error_q <= 1'b0;
            last_q  <= '0;
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            frq_q   <= frq_d;
            csr_q   <= csr_d;
            tmo_q   <= tmo_d;
            gap_q   <= gap_d;
            error_q <= error_d;
            last_q  <= last_d;
            req_q   <= req_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            dat_q   <= dat_d;
        end
    end

    // Nothing reaches the shared bus unless the arbiter currently grants it.
    assign bus_req     = req_q;
    assign wr_dat      = wr_q & bus_gnt;
    assign rd_dat      = rd_q & bus_gnt;
    assign addr_dat    = addr_q & {BUS_ADDR_DATA_LEN{bus_gnt}};
    assign bus_dat_out = dat_q & {8{bus_gnt}};
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign error       = error_q;
    assign last_pllcsr = last_q;

endmodule

// File: tb/tb_atmega_pll_cfg_seq.sv
// Directed bench for atmega_pll_cfg_seq with a small PLL/PLLCSR model and a
// negedge bus monitor that logs every write, read and done pulse.
module tb_atmega_pll_cfg_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  cfg_pllfrq = 8'h00;
    logic [7:0]  cfg_pllcsr = 8'h00;
    logic        bus_req;
    logic        bus_gnt = 1'b0;
    logic [15:0] addr_dat;
    logic        wr_dat;
    logic        rd_dat;
    logic [7:0]  bus_dat_out;
    logic [7:0]  bus_dat_in;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  last_pllcsr;

    int checks = 0;
    int errors = 0;

    atmega_pll_cfg_seq #(
        .BUS_ADDR_DATA_LEN (16),
        .PLLCSR_ADDR       (16'h0049),
        .PLLFRQ_ADDR       (16'h0052),
        .LOCK_TIMEOUT      (16),
        .POLL_GAP          (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .cfg_pllfrq  (cfg_pllfrq),
        .cfg_pllcsr  (cfg_pllcsr),
        .bus_req     (bus_req),
        .bus_gnt     (bus_gnt),
        .addr_dat    (addr_dat),
        .wr_dat      (wr_dat),
        .rd_dat      (rd_dat),
        .bus_dat_out (bus_dat_out),
        .bus_dat_in  (bus_dat_in),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .last_pllcsr (last_pllcsr)
    );

    always #5 clk = ~clk;

    // PLL model: mode 0 locks the cycle after a PLLCSR write, mode 1 never
    // locks, mode 2 reports lock only on the third read.
    int   pll_mode = 0;
    logic model_clr = 1'b0;
    logic lock_armed = 1'b0;
    int   rd_edges = 0;
    logic lock_bit;

    always @(posedge clk) begin
        if (model_clr) begin
            lock_armed <= 1'b0;
            rd_edges   <= 0;
        end else begin
            if (wr_dat && addr_dat == 16'h0049) lock_armed <= 1'b1;
            if (rd_dat) rd_edges <= rd_edges + 1;
        end
    end

    always_comb begin
        lock_bit = 1'b0;
        if (pll_mode == 0)      lock_bit = lock_armed;
        else if (pll_mode == 2) lock_bit = (rd_edges >= 2);
    end

    assign bus_dat_in = {7'b0001001, lock_bit};

    // Monotonic bus logs; tests take a baseline snapshot instead of clearing.
    logic [15:0] wr_addr_log [64];
    logic [7:0]  wr_data_log [64];
    int          wr_cyc_log  [64];
    int wr_n = 0, rd_n = 0, done_n = 0, cyc = 0;
    int base_wr = 0, base_rd = 0, base_done = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (wr_dat) begin
            if (wr_n < 64) begin
                wr_addr_log[wr_n] = addr_dat;
                wr_data_log[wr_n] = bus_dat_out;
                wr_cyc_log[wr_n]  = cyc;
            end
            wr_n = wr_n + 1;
        end
        if (rd_dat) rd_n = rd_n + 1;
        if (done) done_n = done_n + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clearLogs();
        @(negedge clk);
        model_clr = 1'b1;
        base_wr   = wr_n;
        base_rd   = rd_n;
        base_done = done_n;
        @(negedge clk);
        model_clr = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] frq, input logic [7:0] csr);
        @(negedge clk);
        start      = 1'b1;
        cfg_pllfrq = frq;
        cfg_pllcsr = csr;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_idle_in_time"}, 32'(n < 500), 32'd1);
    endtask

    task automatic waitCsrWrite(input string tag);
        int n = 0;
        while (!(wr_dat && addr_dat == 16'h0049) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_csr_write_seen"}, 32'(n < 50), 32'd1);
    endtask

    task automatic checkSeq(input string t, input logic [7:0] frq, input logic [7:0] csr);
        checkOutput({t, "_wr_count"}, 32'(wr_n - base_wr), 32'd2);
        checkOutput({t, "_addr0"}, 32'(wr_addr_log[base_wr]), 32'h52);
        checkOutput({t, "_data0"}, 32'(wr_data_log[base_wr]), 32'(frq));
        checkOutput({t, "_addr1"}, 32'(wr_addr_log[base_wr + 1]), 32'h49);
        checkOutput({t, "_data1"}, 32'(wr_data_log[base_wr + 1]), 32'(csr));
        checkOutput({t, "_back_to_back"}, 32'(wr_cyc_log[base_wr + 1] - wr_cyc_log[base_wr]), 32'd1);
    endtask

    initial begin
        int bad;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset_ctrl", {26'd0, bus_req, wr_dat, rd_dat, busy, done, error}, 32'd0);
        checkOutput("reset_addr", 32'(addr_dat), 32'd0);
        checkOutput("reset_data", {16'd0, bus_dat_out, last_pllcsr}, 32'd0);
        rst_n = 1'b1;

        // T1: grant tied high, lock right after the PLLCSR write
        pll_mode = 0;
        bus_gnt  = 1'b1;
        clearLogs();
        applyStimulus(8'h4A, 8'h12);
        checkOutput("t1_busy_after_start", 32'(busy), 32'd1);
        waitIdle("t1");
        checkSeq("t1", 8'h4A, 8'h12);
        checkOutput("t1_reads", 32'(rd_n - base_rd), 32'd1);
        checkOutput("t1_done", 32'(done_n - base_done), 32'd1);
        checkOutput("t1_error", 32'(error), 32'd0);
        checkOutput("t1_last", 32'(last_pllcsr), 32'h13);

        // T2: grant withheld for 7 cycles in REQ_W
        bus_gnt = 1'b0;
        clearLogs();
        applyStimulus(8'h4A, 8'h12);
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            if (!bus_req || wr_dat || rd_dat || addr_dat != 16'h0 || bus_dat_out != 8'h0) bad++;
            @(negedge clk);
        end
        checkOutput("t2_quiet_before_gnt", 32'(bad), 32'd0);
        checkOutput("t2_no_writes_yet", 32'(wr_n - base_wr), 32'd0);
        bus_gnt = 1'b1;
        waitIdle("t2");
        checkSeq("t2", 8'h4A, 8'h12);
        checkOutput("t2_done", 32'(done_n - base_done), 32'd1);

        // T4: lock on the third poll, which coincides with timeout expiry
        pll_mode = 2;
        clearLogs();
        applyStimulus(8'h31, 8'h02);
        waitIdle("t4");
        checkSeq("t4", 8'h31, 8'h02);
        checkOutput("t4_reads", 32'(rd_n - base_rd), 32'd3);
        checkOutput("t4_last", 32'(last_pllcsr), 32'h13);
        checkOutput("t4_done", 32'(done_n - base_done), 32'd1);
        checkOutput("t4_error", 32'(error), 32'd0);

        // T3: lock never arrives
        pll_mode = 1;
        clearLogs();
        applyStimulus(8'h4A, 8'h12);
        repeat (14) @(negedge clk);
        checkOutput("t3_no_early_error", {30'd0, busy, error}, 32'b10);
        waitIdle("t3");
        checkOutput("t3_error", 32'(error), 32'd1);
        checkOutput("t3_reads", 32'(rd_n - base_rd), 32'd3);
        checkOutput("t3_no_done", 32'(done_n - base_done), 32'd0);
        checkOutput("t3_last", 32'(last_pllcsr), 32'h12);

        // abort with start in IDLE: start dropped, sticky error kept
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checkOutput("abort_start_idle", {29'd0, busy, bus_req, error}, 32'b001);
        repeat (3) @(negedge clk);
        checkOutput("abort_start_still_idle", 32'(busy), 32'd0);

        // T5a: abort during GAP
        clearLogs();
        applyStimulus(8'h4A, 8'h12);
        checkOutput("t5a_error_cleared", 32'(error), 32'd0);
        waitCsrWrite("t5a");
        repeat (2) @(negedge clk);
        checkOutput("t5a_in_gap", {30'd0, busy, bus_req}, 32'b10);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("t5a_bus_idle", {28'd0, bus_req, wr_dat, rd_dat, busy}, 32'd0);
        checkOutput("t5a_error_unchanged", 32'(error), 32'd0);
        repeat (10) @(negedge clk);
        checkOutput("t5a_no_reads", 32'(rd_n - base_rd), 32'd0);
        checkOutput("t5a_no_done", 32'(done_n - base_done), 32'd0);

        // T5b: async reset in the middle of the PLLCSR write
        pll_mode = 0;
        clearLogs();
        applyStimulus(8'h4A, 8'h12);
        waitCsrWrite("t5b");
        rst_n = 1'b0;
        #1;
        checkOutput("t5b_reset_drops_bus", {27'd0, bus_req, wr_dat, rd_dat, busy, error}, 32'd0);
        checkOutput("t5b_reset_addr", 32'(addr_dat), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clearLogs();
        applyStimulus(8'h4A, 8'h12);
        waitIdle("t5b_rerun");
        checkSeq("t5b_rerun", 8'h4A, 8'h12);
        checkOutput("t5b_rerun_done", 32'(done_n - base_done), 32'd1);

        // T6: second start while busy must not change latched cfg
        bus_gnt = 1'b0;
        clearLogs();
        applyStimulus(8'h4A, 8'h12);
        applyStimulus(8'hFF, 8'hEE);
        @(negedge clk);
        bus_gnt = 1'b1;
        waitIdle("t6");
        checkSeq("t6", 8'h4A, 8'h12);
        checkOutput("t6_done", 32'(done_n - base_done), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
